j11bus: RTL and testbench

Bus target for the DCJ11 interface: accepts the single-transaction CPU bus (`busreq`/`busack`) and routes each access to main memory, the 8 KB I/O page, or internal general-purpose/interrupt-acknowledge responders. It sits directly downstream of the J11 pin interface and is its only bus slave. It flags non-existent memory with `buserr`, either by address decode or by a response timeout, so the CPU takes its abort.

---
 rtl/j11bus_pkg.sv | 33 +++
 rtl/j11bus_tmo.sv | 30 +++
 rtl/j11bus.sv | 220 ++++++++++++++++++++++
 tb/tb_j11bus.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/j11bus_pkg.sv
// j11bus_pkg: shared types and constants for the DCJ11 bus target.
package j11bus_pkg;

  localparam int unsigned ADDR_W = 22;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned MEMA_W = 21;
  localparam int unsigned IOA_W  = 12;
  localparam int unsigned IRQV_W = 9;

  // Top 8 KB of the 22-bit space is the I/O page
  localparam logic [8:0] IOPAGE_PFX  = 9'h1FF;
  // GP read code that returns the power-up configuration word
  localparam logic [7:0] GP_CODE_CFG = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_MEM    = 3'd2,
    S_IO     = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  // Request fields captured on the busreq cycle
  typedef struct packed {
    logic              wr;
    logic              gp;
    logic              irq;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        wstrb;
  } bus_req_t;

endpackage

// File: rtl/j11bus_tmo.sv
// j11bus_tmo: clear/enable wait counter with a terminal-count flag.
// tc_c rises when the counter holds TERM; it then stops counting.
module j11bus_tmo #(
  parameter int unsigned TERM = 254
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  localparam int unsigned CW = (TERM > 0) ? $clog2(TERM + 1) : 1;

  logic [CW-1:0] cnt;

  // Count enabled wait cycles, restarting from zero on clr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc_c) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc_c = (cnt == CW'(TERM));

endmodule

// File: rtl/j11bus.sv
// j11bus: DCJ11 bus target routing CPU cycles to RAM, the I/O page,
// or the internal GP / interrupt-acknowledge responders.
// Optional feature: define J11BUS_TIMEOUT_EN to add the NXM response timeout.
module j11bus
  import j11bus_pkg::*;
#(
  parameter logic [21:0] MEMTOP = 22'o1000000,
  parameter logic [15:0] GPCFG  = 16'o173000,
  parameter int unsigned TMO    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        busreq,
  input  logic        buswr,
  input  logic        busgp,
  input  logic        busirq,
  input  logic [21:0] busaddr,
  input  logic [15:0] buswdata,
  input  logic [1:0]  buswstrb,
  input  logic [1:0]  busbs,
  output logic        busack,
  output logic [15:0] busrdata,
  output logic        buserr,
  output logic        memreq,
  output logic        memwr,
  output logic [20:0] memaddr,
  output logic [15:0] memwdata,
  output logic [1:0]  memwstrb,
  input  logic        memack,
  input  logic [15:0] memrdata,
  output logic        ioreq,
  output logic        iowr,
  output logic [11:0] ioaddr,
  output logic [15:0] iowdata,
  output logic [1:0]  iowstrb,
  input  logic        ioack,
  input  logic [15:0] iordata,
  input  logic [8:0]  irqvec,
  output logic        irqack
);

  state_t   state_q, state_d;
  bus_req_t cap_q, cap_d;

  logic              busack_d, buserr_d, irqack_d;
  logic [DATA_W-1:0] busrdata_d;
  logic              memreq_d, memwr_d, ioreq_d, iowr_d;
  logic [MEMA_W-1:0] memaddr_d;
  logic [IOA_W-1:0]  ioaddr_d;
  logic [DATA_W-1:0] memwdata_d, iowdata_d;
  logic [1:0]        memwstrb_d, iowstrb_d;
  logic              tmo_clr, tmo_en, tmo_hit;
  logic              unused_ok;

`ifdef J11BUS_TIMEOUT_EN
  // Response timeout: counts wait cycles in MEM/IO, flags the last allowed one
  j11bus_tmo #(
    .TERM ((TMO > 0) ? TMO - 1 : 0)
  ) u_tmo (
    .clk  (clk),
    .rst  (rst),
    .clr  (tmo_clr),
    .en   (tmo_en),
    .tc_c (tmo_hit)
  );
  assign unused_ok = ^{busbs};
`else
  // No timeout: MEM/IO wait for their ack indefinitely
  assign tmo_hit   = 1'b0;
  assign unused_ok = ^{busbs, tmo_clr, tmo_en, 32'(TMO)};
`endif

  // Next state and next values of every registered output
  always_comb begin
    state_d    = state_q;
    cap_d      = cap_q;
    busack_d   = 1'b0;
    irqack_d   = 1'b0;
    buserr_d   = buserr;
    busrdata_d = busrdata;
    memreq_d   = memreq;
    memwr_d    = memwr;
    memaddr_d  = memaddr;
    memwdata_d = memwdata;
    memwstrb_d = memwstrb;
    ioreq_d    = ioreq;
    iowr_d     = iowr;
    ioaddr_d   = ioaddr;
    iowdata_d  = iowdata;
    iowstrb_d  = iowstrb;
    tmo_clr    = 1'b0;
    tmo_en     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (busreq) begin
          cap_d   = '{wr: buswr, gp: busgp, irq: busirq, addr: busaddr,
                      wdata: buswdata, wstrb: buswstrb};
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        if (cap_q.irq) begin
          state_d    = S_RESP;
          busrdata_d = {7'b0, irqvec};
          buserr_d   = 1'b0;
          irqack_d   = 1'b1;
        end else if (cap_q.gp) begin
          state_d    = S_RESP;
          busrdata_d = (!cap_q.wr && cap_q.addr[7:0] == GP_CODE_CFG) ? GPCFG : '0;
          buserr_d   = 1'b0;
        end else if (cap_q.addr[21:13] == IOPAGE_PFX) begin
          state_d   = S_IO;
          ioreq_d   = 1'b1;
          iowr_d    = cap_q.wr;
          ioaddr_d  = cap_q.addr[12:1];
          iowdata_d = cap_q.wdata;
          iowstrb_d = cap_q.wstrb;
          tmo_clr   = 1'b1;
        end else if (cap_q.addr < MEMTOP) begin
          state_d    = S_MEM;
          memreq_d   = 1'b1;
          memwr_d    = cap_q.wr;
          memaddr_d  = cap_q.addr[21:1];
          memwdata_d = cap_q.wdata;
          memwstrb_d = cap_q.wstrb;
          tmo_clr    = 1'b1;
        end else begin
          state_d    = S_RESP;
          busrdata_d = '0;
          buserr_d   = 1'b1;
        end
      end

      S_MEM: begin
        tmo_en = 1'b1;
        if (memack) begin
          state_d    = S_RESP;
          memreq_d   = 1'b0;
          busrdata_d = cap_q.wr ? '0 : memrdata;
          buserr_d   = 1'b0;
        end else if (tmo_hit) begin
          state_d    = S_RESP;
          memreq_d   = 1'b0;
          busrdata_d = '0;
          buserr_d   = 1'b1;
        end
      end

      S_IO: begin
        tmo_en = 1'b1;
        if (ioack) begin
          state_d    = S_RESP;
          ioreq_d    = 1'b0;
          busrdata_d = cap_q.wr ? '0 : iordata;
          buserr_d   = 1'b0;
        end else if (tmo_hit) begin
          state_d    = S_RESP;
          ioreq_d    = 1'b0;
          busrdata_d = '0;
          buserr_d   = 1'b1;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d  = S_IDLE;
        memreq_d = 1'b0;
        ioreq_d  = 1'b0;
      end
    endcase

    // busack is high exactly while the FSM sits in RESP
    busack_d = (state_d == S_RESP);
  end

  // State, capture and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cap_q    <= '0;
      busack   <= 1'b0;
      busrdata <= '0;
      buserr   <= 1'b0;
      irqack   <= 1'b0;
      memreq   <= 1'b0;
      memwr    <= 1'b0;
      memaddr  <= '0;
      memwdata <= '0;
      memwstrb <= '0;
      ioreq    <= 1'b0;
      iowr     <= 1'b0;
      ioaddr   <= '0;
      iowdata  <= '0;
      iowstrb  <= '0;
    end else begin
      state_q  <= state_d;
      cap_q    <= cap_d;
      busack   <= busack_d;
      busrdata <= busrdata_d;
      buserr   <= buserr_d;
      irqack   <= irqack_d;
      memreq   <= memreq_d;
      memwr    <= memwr_d;
      memaddr  <= memaddr_d;
      memwdata <= memwdata_d;
      memwstrb <= memwstrb_d;
      ioreq    <= ioreq_d;
      iowr     <= iowr_d;
      ioaddr   <= ioaddr_d;
      iowdata  <= iowdata_d;
      iowstrb  <= iowstrb_d;
    end
  end

endmodule

// File: tb/tb_j11bus.sv
// tb_j11bus: directed and randomized checks of j11bus against a
// behavioural address-map model; the bench plays RAM and I/O devices.
module tb_j11bus;

  localparam logic [21:0] TB_MEMTOP   = 22'o1000000;
  localparam logic [15:0] TB_GPCFG    = 16'o173000;
  localparam int          TB_TMO      = 255;
  localparam logic [21:0] IOPAGE_BASE = 22'o17760000;
  localparam int          K_RESP = 0, K_MEM = 1, K_IO = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busreq = 1'b0, buswr = 1'b0, busgp = 1'b0, busirq = 1'b0;
  logic [21:0] busaddr = '0;
  logic [15:0] buswdata = '0;
  logic [1:0]  buswstrb = '0, busbs = '0;
  logic        busack, buserr;
  logic [15:0] busrdata;
  logic        memreq, memwr, ioreq, iowr, irqack;
  logic [20:0] memaddr;
  logic [11:0] ioaddr;
  logic [15:0] memwdata, iowdata;
  logic [1:0]  memwstrb, iowstrb;
  logic        memack = 1'b0, ioack = 1'b0;
  logic [15:0] memrdata = '0, iordata = '0;
  logic [8:0]  irqvec = '0;

  int n_pass = 0;
  int n_total = 0;

  j11bus #(.MEMTOP(TB_MEMTOP), .GPCFG(TB_GPCFG), .TMO(TB_TMO)) dut (
    .clk(clk), .rst(rst),
    .busreq(busreq), .buswr(buswr), .busgp(busgp), .busirq(busirq),
    .busaddr(busaddr), .buswdata(buswdata), .buswstrb(buswstrb), .busbs(busbs),
    .busack(busack), .busrdata(busrdata), .buserr(buserr),
    .memreq(memreq), .memwr(memwr), .memaddr(memaddr), .memwdata(memwdata),
    .memwstrb(memwstrb), .memack(memack), .memrdata(memrdata),
    .ioreq(ioreq), .iowr(iowr), .ioaddr(ioaddr), .iowdata(iowdata),
    .iowstrb(iowstrb), .ioack(ioack), .iordata(iordata),
    .irqvec(irqvec), .irqack(irqack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Address-map model: where a request goes and what a decode-only reply holds
  function automatic void model(input logic wr, input logic gp, input logic irq,
                                input logic [21:0] addr, input logic [8:0] vec,
                                output int kind, output logic [15:0] data,
                                output logic err);
    kind = K_RESP;
    data = 16'h0;
    err  = 1'b0;
    if (irq) begin
      data = 16'(vec);
    end else if (gp) begin
      if (!wr && (int'(addr) % 256) == 0) data = TB_GPCFG;
    end else if (addr >= IOPAGE_BASE) begin
      kind = K_IO;
    end else if (addr < TB_MEMTOP) begin
      kind = K_MEM;
    end else begin
      err = 1'b1;
    end
  endfunction

  // One complete bus transaction; lat = idle request cycles before the ack
  task automatic run_txn(input string tag, input logic wr, input logic gp,
                         input logic irq, input logic [21:0] addr,
                         input logic [15:0] wd, input logic [1:0] ws,
                         input int lat, input logic [15:0] rd);
    int          kind;
    logic [15:0] edata;
    logic        eerr;
    model(wr, gp, irq, addr, irqvec, kind, edata, eerr);
    busreq = 1'b1; buswr = wr; busgp = gp; busirq = irq;
    busaddr = addr; buswdata = wd; buswstrb = ws;
    busbs = 2'($urandom);
    step();
    busreq = 1'b0;
    buswdata = 16'($urandom);
    busaddr  = 22'($urandom);
    chk({tag, "/ack_t1"}, busack, 0);
    step();
    if (kind == K_RESP) begin
      chk({tag, "/ack_t2"}, busack, 1);
      chk({tag, "/err"}, buserr, eerr);
      if (!(gp && wr && !irq)) chk({tag, "/rdata"}, busrdata, edata);
      chk({tag, "/irqack"}, irqack, irq);
      chk({tag, "/no_mem_io"}, {memreq, ioreq}, 0);
    end else begin
      if (kind == K_MEM) begin
        chk({tag, "/memreq"}, {memreq, ioreq}, 2'b10);
        chk({tag, "/memaddr"}, memaddr, addr / 2);
        chk({tag, "/memwr"}, memwr, wr);
        chk({tag, "/memwstrb"}, memwstrb, ws);
        chk({tag, "/memwdata"}, memwdata, wd);
      end else begin
        chk({tag, "/ioreq"}, {memreq, ioreq}, 2'b01);
        chk({tag, "/ioaddr"}, ioaddr, (addr - IOPAGE_BASE) / 2);
        chk({tag, "/iowr"}, iowr, wr);
        chk({tag, "/iowstrb"}, iowstrb, ws);
        chk({tag, "/iowdata"}, iowdata, wd);
      end
      for (int i = 0; i < lat; i++) step();
      chk({tag, "/wait"}, {busack, (kind == K_MEM) ? memreq : ioreq}, 2'b01);
      if (kind == K_MEM) begin memack = 1'b1; memrdata = rd; end
      else begin ioack = 1'b1; iordata = rd; end
      step();
      memack = 1'b0; ioack = 1'b0;
      memrdata = 16'($urandom); iordata = 16'($urandom);
      chk({tag, "/req_drop"}, {memreq, ioreq}, 0);
      chk({tag, "/ack"}, busack, 1);
      chk({tag, "/err"}, buserr, 0);
      chk({tag, "/rdata"}, busrdata, wr ? 16'h0 : rd);
    end
    step();
    chk({tag, "/ack_end"}, {busack, irqack}, 0);
  endtask

  initial begin
    int          n;
    logic        seen;
    logic [21:0] a;
    logic        wr, gp, irq;
    int          r;

    repeat (3) step();
    rst = 1'b0;
    step();
    chk("reset/outputs", {busack, buserr, memreq, ioreq, irqack, memwr, iowr}, 0);
    chk("reset/data", {busrdata, memaddr, ioaddr}, 0);

    // Directed cases
    run_txn("ram_rd", 1'b0, 1'b0, 1'b0, 22'o001000, 16'h0, 2'b11, 3, 16'o012345);
    chk("ram_rd/memaddr_oct", memaddr, 21'o000400);
    run_txn("io_bwr", 1'b1, 1'b0, 1'b0, 22'o17777566, 16'o000101, 2'b01, 1, 16'h0);
    chk("io_bwr/ioaddr_oct", ioaddr, 12'o7673);
    run_txn("nxm_rd", 1'b0, 1'b0, 1'b0, 22'o01000000, 16'h0, 2'b11, 0, 16'h0);
    run_txn("nxm_top", 1'b0, 1'b0, 1'b0, IOPAGE_BASE - 22'd2, 16'h0, 2'b11, 0, 16'h0);
    run_txn("ram_last", 1'b1, 1'b0, 1'b0, TB_MEMTOP - 22'd2, 16'hBEEF, 2'b10, 0, 16'h0);
    run_txn("gp_cfg", 1'b0, 1'b1, 1'b0, 22'o000000, 16'h0, 2'b11, 0, 16'h0);
    chk("gp_cfg/oct", busrdata, 16'o173000);
    run_txn("gp_other", 1'b0, 1'b1, 1'b0, 22'o000005, 16'h0, 2'b11, 0, 16'h0);
    irqvec = 9'o060;
    run_txn("irq", 1'b0, 1'b0, 1'b1, 22'o000000, 16'h0, 2'b11, 0, 16'h0);
    chk("irq/oct", busrdata, 16'o000060);

`ifdef J11BUS_TIMEOUT_EN
    // Missing ack: request held TMO cycles, then busack with buserr
    busreq = 1'b1; buswr = 1'b0; busgp = 1'b0; busirq = 1'b0;
    busaddr = 22'o17777566;
    step(); busreq = 1'b0; step();
    n = 0;
    while (ioreq === 1'b1 && n < 400) begin n++; step(); end
    chk("tmo/req_cycles", n, TB_TMO);
    chk("tmo/ack_err", {busack, buserr}, 2'b11);
    chk("tmo/rdata", busrdata, 0);
    step();
    chk("tmo/ack_end", busack, 0);
    // Ack in the timeout cycle wins
    busreq = 1'b1; busaddr = 22'o17777566;
    step(); busreq = 1'b0; step();
    n = 1;
    while (n < TB_TMO && ioreq === 1'b1 && busack !== 1'b1) begin step(); n++; end
    chk("tmo_ack/still_req", {busack, ioreq}, 2'b01);
    ioack = 1'b1; iordata = 16'o052525;
    step();
    ioack = 1'b0;
    chk("tmo_ack/ack_noerr", {busack, buserr}, 2'b10);
    chk("tmo_ack/rdata", busrdata, 16'o052525);
    step();
`else
    // Without the timeout the RAM wait is unbounded
    busreq = 1'b1; buswr = 1'b0; busgp = 1'b0; busirq = 1'b0;
    busaddr = 22'o002000;
    step(); busreq = 1'b0; step();
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (busack === 1'b1 || memreq !== 1'b1) seen = 1'b1;
      step();
    end
    chk("nowait/held", {seen, memreq}, 2'b01);
    memack = 1'b1; memrdata = 16'o070707;
    step();
    memack = 1'b0;
    chk("nowait/ack", {busack, buserr, memreq}, 3'b100);
    chk("nowait/rdata", busrdata, 16'o070707);
    step();
`endif

    // Reset during a RAM wait drops memreq at once, no busack
    busreq = 1'b1; buswr = 1'b0; busgp = 1'b0; busirq = 1'b0;
    busaddr = 22'o004000;
    step(); busreq = 1'b0; step(); step();
    chk("rst_mid/pre", memreq, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid/memreq", {memreq, busack}, 0);
    step(); step();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (busack === 1'b1 || memreq === 1'b1) seen = 1'b1;
      step();
    end
    chk("rst_mid/quiet", seen, 0);
    run_txn("rst_mid/next", 1'b0, 1'b0, 1'b0, 22'o004000, 16'h0, 2'b11, 2, 16'o123456);

    // Randomized transactions across all regions
    for (int t = 0; t < 40; t++) begin
      r   = int'($urandom_range(0, 5));
      wr  = 1'($urandom);
      gp  = 1'b0;
      irq = 1'b0;
      case (r)
        0, 5: a = 22'($urandom_range(0, int'(TB_MEMTOP) - 1));
        1:    a = IOPAGE_BASE + 22'($urandom_range(0, 8191));
        2:    a = 22'($urandom_range(int'(TB_MEMTOP), int'(IOPAGE_BASE) - 1));
        3: begin
          gp = 1'b1;
          a  = 22'($urandom);
          if ($urandom_range(0, 1) == 0) a[7:0] = 8'h00;
        end
        default: begin
          irq = 1'b1;
          wr  = 1'b0;
          gp  = 1'($urandom);
          a   = 22'($urandom);
        end
      endcase
      irqvec = 9'($urandom);
      run_txn($sformatf("rnd%0d", t), wr, gp, irq, a, 16'($urandom),
              2'($urandom_range(1, 3)), int'($urandom_range(0, 5)), 16'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
